// File: rtl/x_mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter and its round-robin picker.
package x_mem_arb_pkg;

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_sm_t;

    // Wraps with an explicit compare so non-power-of-2 counts behave.
    function automatic int unsigned mod_inc(input int unsigned val, input int unsigned modulus);
        return ((val + 32'd1) >= modulus) ? 32'd0 : (val + 32'd1);
    endfunction

endpackage

// File: rtl/x_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module x_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          sum_s;
    logic [IW-1:0] cand_s;
    logic        hit_s;

    // Scan from the pointer; the first hit masks all later candidates.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        sum_s  = 0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s       = int'(ptr) + k;
            cand_s      = IW'((sum_s >= N) ? (sum_s - N) : sum_s);
            hit_s       = req[cand_s] & ~any;
            gnt[cand_s] = hit_s;
            idx         = hit_s ? cand_s : idx;
            any         = any | hit_s;
        end
    end

endmodule

// File: rtl/x_mem_arbiter.sv
// Arbitrates N_REQ requesters onto one memory port; grant registered and held until accept.
module x_mem_arbiter
    import x_mem_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ-1:0]      i_req_rnw,
    input  logic [N_REQ-1:0][31:0] i_req_addr,
    input  logic [N_REQ-1:0][31:0] i_req_data,
    output logic [N_REQ-1:0]      o_req_accept,
    output logic [31:0]           o_req_data,
    output logic                  o_valid,
    output logic                  o_rnw,
    output logic [31:0]           o_addr,
    output logic [31:0]           o_data,
    input  logic                  i_accept,
    input  logic [31:0]           i_data,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_abort
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_sm_t          state_r;
    arb_sm_t          state_nxt_s;
    logic [N_REQ-1:0] grant_r;
    logic [IW-1:0]    gidx_r;
    logic [IW-1:0]    ptr_r;

    logic [N_REQ-1:0] pick_gnt_s;
    logic [IW-1:0]    pick_idx_s;
    logic             pick_any_s;

    mem_req_t         cur_s;
    logic             owner_valid_s;
    logic             accept_s;
    logic             abort_s;

    x_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (i_req_valid),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    assign cur_s         = '{rnw: i_req_rnw[gidx_r], addr: i_req_addr[gidx_r], data: i_req_data[gidx_r]};
    assign owner_valid_s = i_req_valid[gidx_r];

    // Next state, downstream mux and accept/abort steering.
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        abort_s      = 1'b0;
        o_valid      = 1'b0;
        o_rnw        = 1'b0;
        o_addr       = 32'd0;
        o_data       = 32'd0;
        o_req_accept = '0;
        o_req_data   = 32'd0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                o_valid = owner_valid_s;
                o_rnw   = cur_s.rnw;
                o_addr  = cur_s.addr;
                o_data  = cur_s.data;
                if (owner_valid_s && i_accept) begin
                    accept_s     = 1'b1;
                    o_req_accept = grant_r;
                    o_req_data   = i_data;
                    state_nxt_s  = IDLE;
                end else if (!owner_valid_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign o_abort = abort_s;
    assign o_grant = grant_r;

    // State, grant and pointer registers; pointer advances only on accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r <= pick_gnt_s;
                        gidx_r  <= pick_idx_s;
                    end else begin
                        grant_r <= '0;
                    end
                end
                BUSY: begin
                    if (accept_s) begin
                        grant_r <= '0;
                        ptr_r   <= (FIXED_PRIO != 0) ? '0 : IW'(mod_inc(32'(gidx_r), N_REQ));
                    end else if (abort_s) begin
                        grant_r <= '0;
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule
